// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if -- signal bundle between the host serial line and the
// wheel setpoint consumers.
//   uart_rxd           serial input, idle high
//   speed0..speed3     wheel setpoints, bit15 = direction, 14:0 = magnitude
//   cmd_valid          1-cycle pulse when speed0..3 load from a good frame
//   frame_err          1-cycle pulse on stop-bit error or checksum mismatch
//   rx_busy            high while a byte is being received
//   wdog_trip          high while the command watchdog has expired
// Modports: master = line driver / setpoint consumer, slave = the receiver.
interface uart_cmd_rx_if;
  logic        uart_rxd;
  logic [15:0] speed0;
  logic [15:0] speed1;
  logic [15:0] speed2;
  logic [15:0] speed3;
  logic        cmd_valid;
  logic        frame_err;
  logic        rx_busy;
  logic        wdog_trip;

  modport master (
    output uart_rxd,
    input  speed0, speed1, speed2, speed3,
    input  cmd_valid, frame_err, rx_busy, wdog_trip
  );

  modport slave (
    input  uart_rxd,
    output speed0, speed1, speed2, speed3,
    output cmd_valid, frame_err, rx_busy, wdog_trip
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx -- UART receiver plus command-frame parser for the host-to-FPGA
// direction of the chassis link. Frames are
//   A5, s0_hi, s0_lo, s1_hi, s1_lo, s2_hi, s2_lo, s3_hi, s3_lo, csum
// with csum the 8-bit wrap-around sum of the 8 data bytes.
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rst   synchronous reset, active-high
//   bus       uart_cmd_rx_if.slave (uart_rxd in; speeds, pulses, status out)
// Optional feature: define CMD_WDOG_EN to zero the setpoints and raise
// wdog_trip when no good frame arrives for WDOG_CYC cycles.
module uart_cmd_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115_200,
  parameter int WDOG_CYC = 25_000_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  uart_cmd_rx_if.slave  bus
);

  localparam int             BIT_CYC   = CLK_FREQ / UART_BPS;
  localparam int             HALF_CYC  = BIT_CYC / 2;
  localparam int             CW        = $clog2(BIT_CYC);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [7:0]     HDR       = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_DATA, P_SUM}           p_state_t;

  // ---------------- byte receiver ----------------
  logic          rxd_s1, rxd_s2, rxd_s3;
  rx_state_t     rx_state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          byte_vld;
  logic          stop_err;
  logic          rx_busy_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rxd_s3    <= 1'b1;
      rx_state  <= R_IDLE;
      cyc_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      byte_vld  <= 1'b0;
      stop_err  <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      rxd_s1   <= bus.uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_s3   <= rxd_s2;
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rxd_s3 && !rxd_s2) begin
            rx_state  <= R_START;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        R_START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            if (rxd_s2) begin
              // Line back high at mid start bit: a glitch, not a byte.
              rx_state  <= R_IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              rx_state <= R_DATA;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt   <= '0;
            shift_reg <= {rxd_s2, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= R_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt   <= '0;
            rx_state  <= R_IDLE;
            rx_busy_q <= 1'b0;
            if (rxd_s2) byte_vld <= 1'b1;
            else        stop_err <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- frame parser ----------------
  p_state_t    p_state;
  logic [2:0]  idx;
  logic [7:0]  sum;
  logic [7:0]  shadow [8];
  logic [15:0] speed0_q, speed1_q, speed2_q, speed3_q;
  logic        cmd_valid_q;
  logic        frame_err_q;
  logic        cmd_load;

  assign cmd_load = byte_vld && (p_state == P_SUM) && (shift_reg == sum);

  // NOTE: the shadow buffer is pure data storage and is always fully rewritten
  // before it is read, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (byte_vld && p_state == P_DATA) shadow[idx] <= shift_reg;
  end

`ifdef CMD_WDOG_EN
  logic [31:0] wdog_cnt;
  logic        wdog_trip_q;
`else
  // Parameter only matters with the watchdog built in.
  logic [31:0] unused_wdog;
  assign unused_wdog = WDOG_CYC;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      p_state     <= P_HUNT;
      idx         <= '0;
      sum         <= '0;
      speed0_q    <= '0;
      speed1_q    <= '0;
      speed2_q    <= '0;
      speed3_q    <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef CMD_WDOG_EN
      wdog_cnt    <= '0;
      wdog_trip_q <= 1'b0;
`endif
    end else begin
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (stop_err) begin
        frame_err_q <= 1'b1;
        p_state     <= P_HUNT;
      end else if (byte_vld) begin
        case (p_state)
          P_HUNT: begin
            if (shift_reg == HDR) begin
              p_state <= P_DATA;
              idx     <= '0;
              sum     <= '0;
            end
          end
          P_DATA: begin
            // 0xA5 here is ordinary data: no resync inside a frame.
            sum <= sum + shift_reg;
            idx <= idx + 1'b1;
            if (idx == 3'd7) p_state <= P_SUM;
          end
          P_SUM: begin
            p_state <= P_HUNT;
            if (cmd_load) begin
              speed0_q    <= {shadow[0], shadow[1]};
              speed1_q    <= {shadow[2], shadow[3]};
              speed2_q    <= {shadow[4], shadow[5]};
              speed3_q    <= {shadow[6], shadow[7]};
              cmd_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: p_state <= P_HUNT;
        endcase
      end
`ifdef CMD_WDOG_EN
      // Trip is registered on the edge the counter reaches WDOG_CYC-1, so it
      // is visible exactly WDOG_CYC-1 cycles after cmd_valid.
      if (cmd_load) begin
        wdog_cnt    <= '0;
        wdog_trip_q <= 1'b0;
      end else if (wdog_cnt == 32'(WDOG_CYC - 2)) begin
        wdog_cnt    <= wdog_cnt + 1'b1;
        wdog_trip_q <= 1'b1;
        speed0_q    <= '0;
        speed1_q    <= '0;
        speed2_q    <= '0;
        speed3_q    <= '0;
      end else if (wdog_cnt != 32'(WDOG_CYC - 1)) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
`endif
    end
  end

  assign bus.speed0    = speed0_q;
  assign bus.speed1    = speed1_q;
  assign bus.speed2    = speed2_q;
  assign bus.speed3    = speed3_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = rx_busy_q;
`ifdef CMD_WDOG_EN
  assign bus.wdog_trip = wdog_trip_q;
`else
  assign bus.wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx -- directed bench for uart_cmd_rx. A bench UART model drives
// frames at BIT_CYC = 64 (50 MHz / 781250) to keep the run short; all expected
// values are hand-computed constants.
module tb_uart_cmd_rx;
  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 781_250;
  localparam int BIT_CYC  = 64;
  localparam int HALF_CYC = 32;
  localparam int WDOG_CYC = 1000;
  // Start-bit drive to cmd_valid: 3 sync/edge cycles, half bit, 9 bits, 1 parse.
  localparam int LAT      = 4 + HALF_CYC + 9 * BIT_CYC;

  localparam logic [79:0] FRAME_A     = 80'hA5_01F4_8064_0000_7FFF_57;
  localparam logic [79:0] FRAME_A_BAD = 80'hA5_01F4_8064_0000_7FFF_58;
  localparam logic [79:0] FRAME_B     = 80'hA5_1234_5678_9ABC_DEF0_38;
  localparam logic [79:0] FRAME_C     = 80'hA5_A500_0001_0203_0405_B4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  uart_cmd_rx_if bus ();

  uart_cmd_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .WDOG_CYC (WDOG_CYC)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, cv_cyc = 0;
  bit busy_seen = 1'b0;
  int t_byte = 0;
  int cv0, fe0;

  always @(negedge sys_clk) begin
    if (bus.cmd_valid) begin
      cv_cnt++;
      cv_cyc = cyc;
    end
    if (bus.frame_err) fe_cnt++;
    if (bus.cmd_valid && bus.frame_err) both_cnt++;
    if (bus.rx_busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge sys_clk);
    t_byte = cyc;
    bus.uart_rxd = 1'b0;
    repeat (BIT_CYC) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (BIT_CYC) @(negedge sys_clk);
    end
    bus.uart_rxd = stop_bit;
    repeat (BIT_CYC) @(negedge sys_clk);
    bus.uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [79:0] f);
    for (int i = 0; i < 10; i++) send_byte(f[79-8*i -: 8], 1'b1);
  endtask

  task automatic mark();
    cv0 = cv_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic check_speeds(input string tag, input logic [63:0] exp);
    check({tag, "_s0"}, 32'(bus.speed0), 32'(exp[63:48]));
    check({tag, "_s1"}, 32'(bus.speed1), 32'(exp[47:32]));
    check({tag, "_s2"}, 32'(bus.speed2), 32'(exp[31:16]));
    check({tag, "_s3"}, 32'(bus.speed3), 32'(exp[15:0]));
  endtask

  initial begin
    bus.uart_rxd = 1'b1;
    repeat (4) @(negedge sys_clk);
    // Reset state
    check_speeds("rst", 64'h0);
    check("rst_cv",   32'(bus.cmd_valid), 32'h0);
    check("rst_fe",   32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.rx_busy),   32'h0);
    check("rst_wdog", 32'(bus.wdog_trip), 32'h0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // 1. Good frame, with exact cmd_valid latency
    mark();
    send_frame(FRAME_A);
    repeat (4) @(negedge sys_clk);
    check("t1_cv",  32'(cv_cnt - cv0), 32'd1);
    check("t1_fe",  32'(fe_cnt - fe0), 32'd0);
    check("t1_lat", 32'(cv_cyc - t_byte), 32'(LAT));
    check_speeds("t1", 64'h01F4_8064_0000_7FFF);

    // 2. Checksum mismatch: one frame_err, speeds held
    mark();
    send_frame(FRAME_A_BAD);
    repeat (4) @(negedge sys_clk);
    check("t2_cv", 32'(cv_cnt - cv0), 32'd0);
    check("t2_fe", 32'(fe_cnt - fe0), 32'd1);
    check_speeds("t2", 64'h01F4_8064_0000_7FFF);

    // 3. Stop bit of byte 3 low, rest of the frame ignored; then a good frame
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hF4, 1'b0);
    for (int i = 3; i < 10; i++) send_byte(FRAME_A[79-8*i -: 8], 1'b1);
    repeat (4) @(negedge sys_clk);
    check("t3_cv", 32'(cv_cnt - cv0), 32'd0);
    check("t3_fe", 32'(fe_cnt - fe0), 32'd1);
    mark();
    send_frame(FRAME_B);
    repeat (4) @(negedge sys_clk);
    check("t3b_cv", 32'(cv_cnt - cv0), 32'd1);
    check_speeds("t3b", 64'h1234_5678_9ABC_DEF0);

    // 4. Short glitch, stray bytes, then a frame with data 0xA5 and a stall
    mark();
    busy_seen = 1'b0;
    @(negedge sys_clk);
    bus.uart_rxd = 1'b0;
    repeat (BIT_CYC / 4) @(negedge sys_clk);
    bus.uart_rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge sys_clk);
    check("t4_busy_seen", 32'(busy_seen), 32'h1);
    check("t4_busy_idle", 32'(bus.rx_busy), 32'h0);
    check("t4_glitch_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send_byte(FRAME_C[79-8*i -: 8], 1'b1);
      if (i == 4) repeat (500) @(negedge sys_clk);
    end
    repeat (4) @(negedge sys_clk);
    check("t4_cv", 32'(cv_cnt - cv0), 32'd1);
    check("t4_fe", 32'(fe_cnt - fe0), 32'd0);
    check_speeds("t4", 64'hA500_0001_0203_0405);

    // 5. Reset after byte 5 of a frame, then a good frame
    mark();
    for (int i = 0; i < 5; i++) send_byte(FRAME_A[79-8*i -: 8], 1'b1);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_speeds("t5_rst", 64'h0);
    check("t5_rst_pulses", 32'((cv_cnt - cv0) + (fe_cnt - fe0)), 32'd0);
    send_frame(FRAME_B);
    repeat (4) @(negedge sys_clk);
    check("t5_cv", 32'(cv_cnt - cv0), 32'd1);
    check_speeds("t5", 64'h1234_5678_9ABC_DEF0);

`ifdef CMD_WDOG_EN
    // 6. Watchdog expiry WDOG_CYC-1 cycles after cmd_valid, cleared by next frame
    while (cyc < cv_cyc + WDOG_CYC - 2) @(negedge sys_clk);
    check("t6_pre_trip",  32'(bus.wdog_trip), 32'h0);
    check("t6_pre_speed", 32'(bus.speed0), 32'h1234);
    @(negedge sys_clk);
    check("t6_trip", 32'(bus.wdog_trip), 32'h1);
    check_speeds("t6_zero", 64'h0);
    repeat (50) @(negedge sys_clk);
    check("t6_hold", 32'(bus.wdog_trip), 32'h1);
    send_frame(FRAME_A);
    repeat (4) @(negedge sys_clk);
    check("t6_clear", 32'(bus.wdog_trip), 32'h0);
    check_speeds("t6_load", 64'h01F4_8064_0000_7FFF);
`else
    // 6. Without the watchdog the setpoints hold and wdog_trip stays low
    repeat (WDOG_CYC + 100) @(negedge sys_clk);
    check("t6_trip", 32'(bus.wdog_trip), 32'h0);
    check_speeds("t6_hold", 64'h1234_5678_9ABC_DEF0);
`endif

    check("never_both", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
